// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory stage.
// Load/store sizes, CSR numbers and store-buffer state.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic {
        SB_EMPTY = 1'b0,
        SB_FULL  = 1'b1
    } sb_state_t;

    // Byte-enable mask for a store; low address bits below the size are ignored.
    function automatic logic [3:0] store_mask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << {off[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated across lanes so the mask alone selects bytes.
    function automatic logic [31:0] store_data(
        input logic [2:0]  f3,
        input logic [31:0] rs2
    );
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// One-entry store buffer between the memory stage and data memory.
// Holds a store until the write port accepts it.
module store_buffer
    import mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        store_i,
    input  logic        load_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  mask_i,
    input  logic        ready_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  mask_o
);

    sb_state_t state_q;
    logic      full;
    logic      hit;
    logic      capture;

    assign full    = (state_q == SB_FULL);
    assign hit     = (addr_o[31:2] == addr_i[31:2]);
    // A load to the buffered word waits for the write: no forwarding path.
    assign stall_o = full & ((store_i & ~ready_i) | (load_i & hit));
    assign capture = store_i & ~stall_o;
    assign valid_o = full;

    // Buffer state and held write fields; a pending store is dropped on reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= SB_EMPTY;
            addr_o  <= '0;
            data_o  <= '0;
            mask_o  <= '0;
        end else if (capture) begin
            state_q <= SB_FULL;
            addr_o  <= {addr_i[31:2], 2'b00};
            data_o  <= data_i;
            mask_o  <= mask_i;
        end else if (full && ready_i) begin
            state_q <= SB_EMPTY;
        end
    end

endmodule

// File: rtl/memory_unit.sv
// Memory pipeline stage: load extract, store buffering,
// cycle/instret counters and the MW writeback register.
module memory_unit
    import mem_pkg::*;
#(
    parameter int CSR_COUNTERS = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        M_stall_o,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isCSR_i,
    input  logic        EM_wbEnable_i,
    input  logic [4:0]  EM_rdId_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    input  logic [31:0] EM_Eresult_i,
    output logic        DMemW_valid_o,
    output logic [31:0] DMemW_addr_o,
    output logic [31:0] DMemW_data_o,
    output logic [3:0]  DMemW_mask_o,
    input  logic        DMemW_ready_i,
    output logic        MW_wbEnable_o,
    output logic [4:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o,
    output logic        MW_retire_o
);

    logic        is_store;
    logic        is_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] csr_data;
    logic [31:0] wb_data;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    assign is_store = EM_isStore_i & ~EM_nop_i;
    assign is_load  = EM_isLoad_i & ~EM_nop_i;

    store_buffer u_sb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .store_i (is_store),
        .load_i  (is_load),
        .addr_i  (EM_addr_i),
        .data_i  (store_data(EM_funct3_i, EM_rs2_i)),
        .mask_i  (store_mask(EM_funct3_i, EM_addr_i[1:0])),
        .ready_i (DMemW_ready_i),
        .stall_o (M_stall_o),
        .valid_o (DMemW_valid_o),
        .addr_o  (DMemW_addr_o),
        .data_o  (DMemW_data_o),
        .mask_o  (DMemW_mask_o)
    );

    // Select the addressed byte/half of the loaded word and extend it.
    always_comb begin
        ld_half = EM_addr_i[1] ? EM_Mdata_i[31:16] : EM_Mdata_i[15:0];
        case (EM_addr_i[1:0])
            2'b00:   ld_byte = EM_Mdata_i[7:0];
            2'b01:   ld_byte = EM_Mdata_i[15:8];
            2'b10:   ld_byte = EM_Mdata_i[23:16];
            default: ld_byte = EM_Mdata_i[31:24];
        endcase
        case (EM_funct3_i)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = EM_Mdata_i;
        endcase
    end

    // Counter read mux; values are those before this cycle's increment.
    always_comb begin
        csr_data = '0;
        if (CSR_COUNTERS != 0) begin
            case (EM_csrId_i)
                CSR_CYCLE,    CSR_MCYCLE:    csr_data = mcycle_q[31:0];
                CSR_CYCLEH,   CSR_MCYCLEH:   csr_data = mcycle_q[63:32];
                CSR_INSTRET,  CSR_MINSTRET:  csr_data = minstret_q[31:0];
                CSR_INSTRETH, CSR_MINSTRETH: csr_data = minstret_q[63:32];
                default:                     csr_data = '0;
            endcase
        end
    end

    // Writeback source priority: load, then CSR, then execute result.
    always_comb begin
        wb_data = EM_Eresult_i;
        if (is_load) begin
            wb_data = ld_data;
        end else if (EM_isCSR_i) begin
            wb_data = csr_data;
        end
    end

    // Free-running 64-bit counters; instret counts instructions leaving the stage.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (!EM_nop_i && !M_stall_o) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    // MW pipeline register; a stall inserts a bubble downstream.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            MW_wbEnable_o <= 1'b0;
            MW_rdId_o     <= '0;
            MW_wbData_o   <= '0;
            MW_retire_o   <= 1'b0;
        end else begin
            MW_rdId_o   <= EM_rdId_i;
            MW_wbData_o <= wb_data;
            if (M_stall_o) begin
                MW_wbEnable_o <= 1'b0;
                MW_retire_o   <= 1'b0;
            end else begin
                MW_wbEnable_o <= EM_wbEnable_i & ~EM_nop_i
                               & (EM_rdId_i != 5'd0);
                MW_retire_o   <= ~EM_nop_i;
            end
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: loads, stores, buffer
// stalls, counters and asynchronous reset.
module tb_memory_unit;

    logic        clk_i;
    logic        reset_i;
    logic        M_stall_o;
    logic        EM_nop_i;
    logic        EM_isLoad_i;
    logic        EM_isStore_i;
    logic        EM_isCSR_i;
    logic        EM_wbEnable_i;
    logic [4:0]  EM_rdId_i;
    logic [11:0] EM_csrId_i;
    logic [2:0]  EM_funct3_i;
    logic [31:0] EM_rs2_i;
    logic [31:0] EM_addr_i;
    logic [31:0] EM_Mdata_i;
    logic [31:0] EM_Eresult_i;
    logic        DMemW_valid_o;
    logic [31:0] DMemW_addr_o;
    logic [31:0] DMemW_data_o;
    logic [3:0]  DMemW_mask_o;
    logic        DMemW_ready_i;
    logic        MW_wbEnable_o;
    logic [4:0]  MW_rdId_o;
    logic [31:0] MW_wbData_o;
    logic        MW_retire_o;

    int checks;
    int failures;

    memory_unit #(.CSR_COUNTERS(1)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .M_stall_o     (M_stall_o),
        .EM_nop_i      (EM_nop_i),
        .EM_isLoad_i   (EM_isLoad_i),
        .EM_isStore_i  (EM_isStore_i),
        .EM_isCSR_i    (EM_isCSR_i),
        .EM_wbEnable_i (EM_wbEnable_i),
        .EM_rdId_i     (EM_rdId_i),
        .EM_csrId_i    (EM_csrId_i),
        .EM_funct3_i   (EM_funct3_i),
        .EM_rs2_i      (EM_rs2_i),
        .EM_addr_i     (EM_addr_i),
        .EM_Mdata_i    (EM_Mdata_i),
        .EM_Eresult_i  (EM_Eresult_i),
        .DMemW_valid_o (DMemW_valid_o),
        .DMemW_addr_o  (DMemW_addr_o),
        .DMemW_data_o  (DMemW_data_o),
        .DMemW_mask_o  (DMemW_mask_o),
        .DMemW_ready_i (DMemW_ready_i),
        .MW_wbEnable_o (MW_wbEnable_o),
        .MW_rdId_o     (MW_rdId_o),
        .MW_wbData_o   (MW_wbData_o),
        .MW_retire_o   (MW_retire_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        EM_nop_i      = 1'b1;
        EM_isLoad_i   = 1'b0;
        EM_isStore_i  = 1'b0;
        EM_isCSR_i    = 1'b0;
        EM_wbEnable_i = 1'b0;
        EM_rdId_i     = '0;
        EM_csrId_i    = '0;
        EM_funct3_i   = '0;
        EM_rs2_i      = '0;
        EM_addr_i     = '0;
        EM_Mdata_i    = '0;
        EM_Eresult_i  = '0;
    endtask

    task automatic csr(input logic [11:0] id, input logic [4:0] rd);
        idle();
        EM_nop_i      = 1'b0;
        EM_isCSR_i    = 1'b1;
        EM_wbEnable_i = 1'b1;
        EM_csrId_i    = id;
        EM_rdId_i     = rd;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] md, input logic [4:0] rd);
        idle();
        EM_nop_i      = 1'b0;
        EM_isLoad_i   = 1'b1;
        EM_wbEnable_i = 1'b1;
        EM_funct3_i   = f3;
        EM_addr_i     = a;
        EM_Mdata_i    = md;
        EM_rdId_i     = rd;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
        idle();
        EM_nop_i     = 1'b0;
        EM_isStore_i = 1'b1;
        EM_funct3_i  = f3;
        EM_addr_i    = a;
        EM_rs2_i     = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_i  = 1'b0;
        DMemW_ready_i = 1'b0;
        idle();
        #3;
        chk("rst_valid", DMemW_valid_o, 0);
        chk("rst_stall", M_stall_o, 0);
        chk("rst_wben", MW_wbEnable_o, 0);
        chk("rst_retire", MW_retire_o, 0);
        chk("rst_wbdata", MW_wbData_o, 0);
        chk("rst_rd", MW_rdId_o, 0);
        tick();
        tick();
        chk("rst_hold_retire", MW_retire_o, 0);
        reset_i = 1'b1;

        // counters: first counting edge follows the release
        csr(12'hC00, 5'd1);
        tick();
        chk("mcycle_first", MW_wbData_o, 32'd0);
        chk("csr_wben", MW_wbEnable_o, 1);
        chk("csr_rd", MW_rdId_o, 5'd1);
        chk("csr_retire", MW_retire_o, 1);
        tick();
        chk("mcycle_second", MW_wbData_o, 32'd1);
        csr(12'hB02, 5'd1);
        tick();
        chk("minstret_2", MW_wbData_o, 32'd2);
        csr(12'hC80, 5'd1);
        tick();
        chk("mcycle_hi", MW_wbData_o, 32'd0);
        csr(12'hB00, 5'd1);
        EM_nop_i = 1'b1;
        tick();
        chk("nop_wben", MW_wbEnable_o, 0);
        chk("nop_retire", MW_retire_o, 0);
        csr(12'hC02, 5'd1);
        tick();
        chk("minstret_skip_nop", MW_wbData_o, 32'd4);
        csr(12'h7C0, 5'd1);
        tick();
        chk("csr_unknown", MW_wbData_o, 32'd0);
        csr(12'hC82, 5'd1);
        tick();
        chk("minstret_hi", MW_wbData_o, 32'd0);
        csr(12'hB00, 5'd1);
        tick();
        chk("mcycle_8", MW_wbData_o, 32'd8);

        // rd = 0 never writes back
        idle();
        EM_nop_i      = 1'b0;
        EM_wbEnable_i = 1'b1;
        EM_Eresult_i  = 32'hDEADBEEF;
        tick();
        chk("alu_data", MW_wbData_o, 32'hDEADBEEF);
        chk("alu_rd0_wben", MW_wbEnable_o, 0);
        chk("alu_retire", MW_retire_o, 1);

        // load extraction
        ld(3'b000, 32'h1003, 32'h80FF_1234, 5'd5);
        tick();
        chk("lb", MW_wbData_o, 32'hFFFF_FF80);
        chk("lb_rd", MW_rdId_o, 5'd5);
        ld(3'b100, 32'h1003, 32'h80FF_1234, 5'd5);
        tick();
        chk("lbu", MW_wbData_o, 32'h0000_0080);
        ld(3'b001, 32'h1002, 32'h80FF_1234, 5'd5);
        tick();
        chk("lh_hi", MW_wbData_o, 32'hFFFF_80FF);
        ld(3'b101, 32'h1000, 32'h80FF_1234, 5'd5);
        tick();
        chk("lhu_lo", MW_wbData_o, 32'h0000_1234);
        ld(3'b010, 32'h1000, 32'h80FF_1234, 5'd5);
        tick();
        chk("lw", MW_wbData_o, 32'h80FF_1234);
        ld(3'b000, 32'h1001, 32'h80FF_1234, 5'd5);
        tick();
        chk("lb_b1", MW_wbData_o, 32'h0000_0012);

        // SH with ready high
        DMemW_ready_i = 1'b1;
        st(3'b001, 32'h2002, 32'h0000_ABCD);
        #1;
        chk("sh_nostall", M_stall_o, 0);
        tick();
        chk("sh_valid", DMemW_valid_o, 1);
        chk("sh_addr", DMemW_addr_o, 32'h2000);
        chk("sh_mask", DMemW_mask_o, 4'b1100);
        chk("sh_data", DMemW_data_o, 32'hABCD_ABCD);
        idle();
        tick();
        chk("sh_drained", DMemW_valid_o, 0);

        // SB lane 1
        st(3'b000, 32'h6001, 32'h0000_00A5);
        tick();
        chk("sb_addr", DMemW_addr_o, 32'h6000);
        chk("sb_mask", DMemW_mask_o, 4'b0010);
        chk("sb_data", DMemW_data_o, 32'hA5A5_A5A5);
        idle();
        tick();
        chk("sb_drained", DMemW_valid_o, 0);

        // back-to-back SW, ready low for three cycles
        DMemW_ready_i = 1'b0;
        st(3'b010, 32'h4000, 32'h1111_1111);
        #1;
        chk("b2b_first_nostall", M_stall_o, 0);
        tick();
        chk("b2b_a_valid", DMemW_valid_o, 1);
        chk("b2b_a_addr", DMemW_addr_o, 32'h4000);
        st(3'b010, 32'h4008, 32'h2222_2222);
        #1;
        chk("b2b_stall1", M_stall_o, 1);
        tick();
        chk("b2b_bubble", MW_retire_o, 0);
        chk("b2b_stall2", M_stall_o, 1);
        chk("b2b_hold_addr", DMemW_addr_o, 32'h4000);
        tick();
        chk("b2b_stall3", M_stall_o, 1);
        chk("b2b_hold_valid", DMemW_valid_o, 1);
        DMemW_ready_i = 1'b1;
        #1;
        chk("b2b_release", M_stall_o, 0);
        chk("b2b_a_data", DMemW_data_o, 32'h1111_1111);
        tick();
        chk("b2b_b_valid", DMemW_valid_o, 1);
        chk("b2b_b_addr", DMemW_addr_o, 32'h4008);
        chk("b2b_b_data", DMemW_data_o, 32'h2222_2222);
        chk("b2b_b_mask", DMemW_mask_o, 4'b1111);
        chk("b2b_b_retire", MW_retire_o, 1);
        idle();
        tick();
        chk("b2b_drained", DMemW_valid_o, 0);

        // load to the buffered word waits for the drain
        DMemW_ready_i = 1'b0;
        st(3'b010, 32'h3000, 32'h3333_3333);
        tick();
        ld(3'b010, 32'h3000, 32'h3333_3333, 5'd7);
        #1;
        chk("hit_stall", M_stall_o, 1);
        tick();
        chk("hit_bubble", MW_wbEnable_o, 0);
        chk("hit_stall_held", M_stall_o, 1);
        DMemW_ready_i = 1'b1;
        #1;
        chk("hit_stall_ready", M_stall_o, 1);
        tick();
        chk("hit_drained", DMemW_valid_o, 0);
        chk("hit_unstall", M_stall_o, 0);
        DMemW_ready_i = 1'b0;
        tick();
        chk("hit_load_data", MW_wbData_o, 32'h3333_3333);
        chk("hit_load_wben", MW_wbEnable_o, 1);
        chk("hit_load_rd", MW_rdId_o, 5'd7);

        // load to a different word proceeds
        st(3'b010, 32'h3000, 32'h5555_5555);
        tick();
        ld(3'b010, 32'h3004, 32'h4444_4444, 5'd8);
        #1;
        chk("miss_nostall", M_stall_o, 0);
        tick();
        chk("miss_data", MW_wbData_o, 32'h4444_4444);
        chk("miss_buf_valid", DMemW_valid_o, 1);

        // asynchronous reset while full and stalled
        st(3'b010, 32'h5000, 32'h6666_6666);
        #1;
        chk("pre_rst_stall", M_stall_o, 1);
        reset_i = 1'b0;
        #1;
        chk("arst_valid", DMemW_valid_o, 0);
        chk("arst_stall", M_stall_o, 0);
        chk("arst_wben", MW_wbEnable_o, 0);
        chk("arst_wbdata", MW_wbData_o, 0);
        idle();
        tick();
        reset_i = 1'b1;
        csr(12'hC00, 5'd2);
        tick();
        chk("arst_mcycle", MW_wbData_o, 32'd0);
        chk("arst_discard", DMemW_valid_o, 0);
        csr(12'hB02, 5'd2);
        tick();
        chk("arst_minstret", MW_wbData_o, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
